// File: rtl/fifo_stream_out.sv
// Read-side drain stage: issues FIFO read pulses against a 2-entry skid buffer
// and presents the captured RAM words on a valid/ready stream.
module fifo_stream_out #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  logic [1:0]        occ;
  logic              inflight;
  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;
  logic              pop;
  logic              capture;
  logic [2:0]        credit;
  logic [1:0]        base;

  assign out_valid = (occ != 2'd0);
  assign out_data  = slot0;
  assign level     = occ;
  assign pop       = out_valid && out_ready;
  assign capture   = inflight && !flush;

  // Words held plus words in flight, minus the one leaving this cycle.
  // Evaluated at 3 bits so occ + inflight never wraps.
  assign credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_read = reset && !fifo_empty && !flush && (credit < 3'd2);

  // Slot index that an arriving word lands in, after any pop shift.
  assign base      = occ - {1'b0, pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      slot0    <= '0;
      slot1    <= '0;
    end else if (flush) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_read;
      occ      <= base + {1'b0, capture};
      if (pop)
        slot0 <= slot1;
      // A capture into slot0 overrides the shift above when both happen.
      if (capture) begin
        if (base == 2'd0)
          slot0 <= ram_rdata;
        else
          slot1 <= ram_rdata;
      end
    end
  end

endmodule
